// File: rtl/countdown_timer_pkg.sv
// Shared types for the loadable countdown timer.
package countdown_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_e;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot or periodic (auto-reload) operation and a
// registered one-cycle expired pulse on the terminal tick.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             auto_reload,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expired
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  timer_state_e     state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic             expired_reg, expired_next;

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    reload_next  = reload_reg;
    expired_next = 1'b0;

    if (load) begin
      count_next  = load_value;
      reload_next = load_value;
      state_next  = (load_value != ZERO) ? RUN : IDLE;
    end else if (state_reg == RUN) begin
      if (stop) begin
        state_next = IDLE;
      end else if (enable) begin
        // Terminal tick at 1 so the count never wraps below zero.
        if (count_reg <= ONE) begin
          expired_next = 1'b1;
          if (auto_reload) begin
            count_next = reload_reg;
          end else begin
            count_next = ZERO;
            state_next = IDLE;
          end
        end else begin
          count_next = count_reg - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      count_reg   <= ZERO;
      reload_reg  <= ZERO;
      expired_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      reload_reg  <= reload_next;
      expired_reg <= expired_next;
    end
  end

  assign count   = count_reg;
  assign busy    = (state_reg == RUN);
  assign expired = expired_reg;

endmodule
